// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Word FIFO feeding a UART transmitter through its DIN/OE/RDY
//            handshake; one registered load strobe per stored word.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WDATA = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WDATA-1:0]         DIN,
    input  logic                     WE,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    input  logic                     CLR,
    output logic [WDATA-1:0]         TXDOUT,
    output logic                     TXOE,
    input  logic                     TXRDY
);

    localparam int               c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL_CNT = DEPTH[c_AW:0];

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [WDATA-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_ovf;
    logic [1:0]       r_state;
    logic [WDATA-1:0] r_txdout;
    logic             r_txoe;

    logic             w_wr;
    logic             w_pop;
    logic [c_AW:0]    w_count_nxt;

    // Acceptance uses the registered FULL, so a same-cycle pop never frees room.
    assign w_wr  = WE && !r_full;
    assign w_pop = ((r_state == c_IDLE) || (r_state == c_WAIT)) && TXRDY && !r_empty;

    assign w_count_nxt = r_count + {{c_AW{1'b0}}, w_wr} - {{c_AW{1'b0}}, w_pop};

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wptr] <= DIN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (WE && r_full) begin
            r_ovf <= 1'b1;
        end else if (CLR) begin
            r_ovf <= 1'b0;
        end
    end

    // Issue FSM: one-cycle load strobe, then wait for the transmitter to return.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= c_IDLE;
            r_txoe   <= 1'b0;
            r_txdout <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_state  <= c_ISSUE;
                        r_txoe   <= 1'b1;
                        r_txdout <= r_mem[r_rptr];
                    end
                end
                c_ISSUE: begin
                    r_state <= c_WAIT;
                    r_txoe  <= 1'b0;
                end
                c_WAIT: begin
                    if (w_pop) begin
                        r_state  <= c_ISSUE;
                        r_txoe   <= 1'b1;
                        r_txdout <= r_mem[r_rptr];
                    end else if (TXRDY) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_txoe  <= 1'b0;
                end
            endcase
        end
    end

    assign FULL   = r_full;
    assign EMPTY  = r_empty;
    assign COUNT  = r_count;
    assign OVF    = r_ovf;
    assign TXDOUT = r_txdout;
    assign TXOE   = r_txoe;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo with a behavioural UART
//            transmitter and an in-order scoreboard of issued words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int WD  = 8;
    localparam int DP  = 16;
    localparam int BIT = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [WD-1:0] DIN = '0;
    logic          WE  = 1'b0;
    logic          CLR = 1'b0;
    logic          FULL;
    logic          EMPTY;
    logic [4:0]    COUNT;
    logic          OVF;
    logic [WD-1:0] TXDOUT;
    logic          TXOE;
    logic          TXRDY;

    logic          tx_busy = 1'b0;
    logic [9:0]    tx_sh   = '1;
    int            tx_cnt  = 0;
    logic          hold    = 1'b0;
    logic          TXD;

    logic [WD-1:0] sb[$];
    int            n_chk  = 0;
    int            n_err  = 0;
    bit            gap_en = 1'b0;
    int            rdy_run = 0;
    logic          prev_oe = 1'b0;

    uart_tx_fifo #(.WDATA(WD), .DEPTH(DP)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DIN    (DIN),
        .WE     (WE),
        .FULL   (FULL),
        .EMPTY  (EMPTY),
        .COUNT  (COUNT),
        .OVF    (OVF),
        .CLR    (CLR),
        .TXDOUT (TXDOUT),
        .TXOE   (TXOE),
        .TXRDY  (TXRDY)
    );

    always #5 CLK = ~CLK;

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, BIT clocks each.
    assign TXRDY = !tx_busy && !hold;
    assign TXD   = tx_busy ? tx_sh[0] : 1'b1;

    always @(posedge CLK) begin
        if (!tx_busy) begin
            if (TXOE) begin
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, TXDOUT, 1'b0};
                tx_cnt  <= 0;
            end
        end else begin
            if (tx_cnt % BIT == BIT - 1) tx_sh <= {1'b1, tx_sh[9:1]};
            if (tx_cnt == 10 * BIT - 1) tx_busy <= 1'b0;
            tx_cnt <= tx_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (TXOE) begin
                chk("oe_consec", {31'd0, prev_oe}, 32'd0);
                chk("sb_avail", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) chk("txdout_order", {24'd0, TXDOUT}, {24'd0, sb.pop_front()});
                if (gap_en) chk("issue_gap", rdy_run, 1);
                rdy_run = 0;
            end else if (TXRDY) begin
                rdy_run++;
            end else begin
                rdy_run = 0;
            end
        end
        prev_oe = TXOE;
    end

    task automatic wr(input logic [WD-1:0] d, input bit acc);
        WE  = 1'b1;
        DIN = d;
        @(posedge CLK);
        if (acc) sb.push_back(d);
        #1 WE = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_drain(input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge CLK);
            done = EMPTY && TXRDY && !TXOE && (sb.size() == 0);
        end
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] fr;
        int         oe_n;
        bit         fin;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_txoe", TXOE, 0);
        chk("rst_txdout", TXDOUT, 0);
        @(negedge CLK);
        RST = 1'b0;

        oe_n = 0;
        repeat (100) begin
            @(negedge CLK);
            if (TXOE) oe_n++;
        end
        chk("idle_no_txoe", oe_n, 0);
        chk("idle_empty", EMPTY, 1);

        // Single word into an empty FIFO with transmitter idle
        WE  = 1'b1;
        DIN = 8'hA5;
        @(posedge CLK);
        sb.push_back(8'hA5);
        #1 WE = 1'b0;
        chk("single_cnt1", COUNT, 1);
        chk("single_oe_early", TXOE, 0);
        @(posedge CLK);
        #1;
        chk("single_oe", TXOE, 1);
        chk("single_dout", TXDOUT, 8'hA5);
        chk("single_cnt0", COUNT, 0);
        @(posedge CLK);
        #1;
        chk("single_oe_pulse", TXOE, 0);
        for (int i = 0; i < 10; i++) begin
            fr[i] = TXD;
            repeat (BIT) @(posedge CLK);
            #1;
        end
        chk("single_frame", {22'd0, fr}, {22'd0, 1'b1, 8'hA5, 1'b0});
        wait_drain(100);

        // Burst to full with transmitter held busy, then overflow + CLR
        hold = 1'b1;
        for (int d = 1; d <= 16; d++) wr(8'(d), 1'b1);
        chk("burst_full", FULL, 1);
        chk("burst_count", COUNT, 16);
        chk("burst_ovf0", OVF, 0);
        WE  = 1'b1;
        DIN = 8'hFF;
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        WE  = 1'b0;
        CLR = 1'b0;
        chk("ovf_set_over_clr", OVF, 1);
        chk("ovf_count", COUNT, 16);
        @(negedge CLK);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        chk("ovf_clr", OVF, 0);
        chk("clr_keeps_full", FULL, 1);
        gap_en = 1'b1;
        hold   = 1'b0;
        wait_drain(16 * 50);
        gap_en = 1'b0;

        // Pointer wrap: 10 then 12 words
        @(negedge CLK);
        for (int i = 0; i < 10; i++) wr(8'(8'h40 + i), 1'b1);
        wait_drain(600);
        for (int i = 0; i < 12; i++) wr(8'(8'h60 + i), 1'b1);
        wait_drain(700);
        chk("wrap_count", COUNT, 0);

        // Simultaneous accepted write and pop at COUNT=5
        hold = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'(8'h80 + i), 1'b1);
        chk("simul_pre", COUNT, 5);
        hold = 1'b0;
        WE   = 1'b1;
        DIN  = 8'h55;
        @(posedge CLK);
        sb.push_back(8'h55);
        #1 WE = 1'b0;
        chk("simul_count", COUNT, 5);
        chk("simul_issue", TXOE, 1);
        wait_drain(8 * 50);

        // Reset mid-frame with 4 words queued
        for (int i = 0; i < 5; i++) wr(8'(8'h30 + i), 1'b1);
        repeat (10) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst_count", COUNT, 0);
        chk("midrst_txoe", TXOE, 0);
        chk("midrst_empty", EMPTY, 1);
        chk("midrst_inflight", tx_busy, 1);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        fin  = 1'b0;
        oe_n = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge CLK);
            if (!tx_busy) fin = 1'b1;
            if (TXOE) oe_n++;
        end
        chk("midrst_frame_done", fin, 1);
        chk("midrst_no_txoe", oe_n, 0);
        wr(8'h3C, 1'b1);
        wait_drain(200);
        chk("final_count", COUNT, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
